// File: rtl/yarp_pkg.sv
// ---------------------------------------------------------------------------
// yarp_pkg
// Shared definitions for the YARP core front end.
//   YARP_XLEN     : default datapath width
//   PC_INCR       : byte distance between sequential instructions
//   fetch_state_e : states of the instruction-fetch sequencer
// ---------------------------------------------------------------------------
package yarp_pkg;

  localparam int unsigned YARP_XLEN = 32;
  localparam int unsigned PC_INCR   = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/yarp_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// yarp_fetch_ctrl
// Instruction-fetch sequencer feeding the decoder. Owns the PC, issues one
// request at a time to instruction memory (req/gnt/rvalid), holds the returned
// word for the decoder under a valid/ready handshake, and applies PC redirects,
// discarding any in-flight wrong-path response.
//
// Ports
//   clk, reset              clock and synchronous active-high reset
//   imem_req_o/imem_addr_o  fetch request and word-aligned fetch address
//   imem_gnt_i              memory accepted the request this cycle
//   imem_rvalid_i/rdata_i   response strobe and instruction word
//   instr_valid_o/instr_o   held instruction for the decoder
//   pc_o                    address of instr_o
//   instr_ready_i           consumer accepts instr_o this cycle
//   redirect_i/redirect_pc_i next-PC override and its target
//   fetch_err_o             sticky misaligned-redirect flag (only when
//                           YARP_FETCH_MISALIGN_EN is defined)
//
// Configuration
//   YARP_FETCH_MISALIGN_EN : a misaligned redirect target sets fetch_err_o and
//   parks the sequencer in IDLE until reset (after absorbing any in-flight
//   response). Without it, the low two target bits are simply cleared.
// ---------------------------------------------------------------------------
module yarp_fetch_ctrl
  import yarp_pkg::*;
#(
  parameter int unsigned     XLEN     = YARP_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_1000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i
`ifdef YARP_FETCH_MISALIGN_EN
  ,
  output logic            fetch_err_o
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_hold_q, pc_hold_d;
  logic [XLEN-1:0] target;
  logic            halt;

`ifdef YARP_FETCH_MISALIGN_EN
  logic err_q, err_d, misalign;

  // The raw target is kept so the error case is observable; halt covers both
  // a fresh misaligned redirect and an error latched earlier.
  assign target      = redirect_pc_i;
  assign misalign    = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign err_d       = err_q | misalign;
  assign halt        = err_d;
  assign fetch_err_o = err_q;
`else
  logic unused_redirect_lsbs;

  // Without misalignment checking the target is silently word-aligned.
  assign target               = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign halt                 = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
`endif

  // Next-state and output decode. Redirect always rewrites the PC first;
  // HOLD's sequential increment is only taken when no redirect is present,
  // which gives redirect priority over ready and rvalid everywhere.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_hold_d     = pc_hold_q;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    imem_addr_o   = {pc_q[XLEN-1:2], 2'b00};

    if (redirect_i) begin
      pc_d = target;
    end

    case (state_q)
      IDLE: begin
        if (!halt) begin
          state_d = REQ;
        end
      end

      REQ: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) begin
          // A granted request always returns a word; after a redirect it
          // is stale and must be absorbed in DRAIN.
          state_d = redirect_i ? DRAIN : WAIT;
        end else if (redirect_i && halt) begin
          state_d = IDLE;
        end
      end

      WAIT: begin
        if (redirect_i) begin
          if (imem_rvalid_i) begin
            state_d = halt ? IDLE : REQ;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_rvalid_i) begin
          state_d   = HOLD;
          instr_d   = imem_rdata_i;
          pc_hold_d = pc_q;
        end
      end

      DRAIN: begin
        if (imem_rvalid_i) begin
          state_d = halt ? IDLE : REQ;
        end
      end

      HOLD: begin
        instr_valid_o = 1'b1;
        if (redirect_i) begin
          state_d = halt ? IDLE : REQ;
        end else if (instr_ready_i) begin
          pc_d    = pc_q + XLEN'(PC_INCR);
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC and held-instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      pc_hold_q <= RESET_PC;
`ifdef YARP_FETCH_MISALIGN_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_hold_q <= pc_hold_d;
`ifdef YARP_FETCH_MISALIGN_EN
      err_q     <= err_d;
`endif
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_hold_q;

endmodule

// File: tb/tb_yarp_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_yarp_fetch_ctrl
// Directed bench for yarp_fetch_ctrl: a table of per-cycle vectors for the
// main fetch/accept/redirect flow, followed by hand-written sequences for
// stale-response draining, misaligned redirects and mid-transaction reset.
// ---------------------------------------------------------------------------
module tb_yarp_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
`ifdef YARP_FETCH_MISALIGN_EN
  logic        fetch_err_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic saw_dropped = 1'b0;

  typedef struct {
    string       name;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        redirect;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        chk_data;
  } vec_t;

  vec_t vec_q[$];

  yarp_fetch_ctrl #(
    .XLEN     (32),
    .RESET_PC (32'h0000_1000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
`ifdef YARP_FETCH_MISALIGN_EN
    ,
    .fetch_err_o   (fetch_err_o)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Any wrong-path word ever presented as a valid instruction is an error.
  always @(negedge clk) begin
    if (!reset && instr_valid_o &&
        (instr_o == 32'hDEAD_BEEF || instr_o == 32'h0000_0BAD || instr_o == 32'h0000_CAFE)) begin
      saw_dropped = 1'b1;
    end
  end

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic apply_stimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                                input logic ready, input logic redirect, input logic [31:0] rpc);
    imem_gnt_i    = gnt;
    imem_rvalid_i = rvalid;
    imem_rdata_i  = rdata;
    instr_ready_i = ready;
    redirect_i    = redirect;
    redirect_pc_i = rpc;
    @(posedge clk);
    #1;
  endtask

  // Compare the current outputs; instr/pc are only meaningful when chk_data.
  task automatic check_output(input string name, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic chk_data);
    logic bad;
    bad = (imem_req_o !== e_req) || (imem_addr_o !== e_addr) || (instr_valid_o !== e_valid);
    if (chk_data) begin
      bad = bad || (instr_o !== e_instr) || (pc_o !== e_pc);
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("[TB] FAIL %s: got req=%0b addr=%h valid=%0b instr=%h pc=%h, want req=%0b addr=%h valid=%0b instr=%h pc=%h",
               name, imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
               e_req, e_addr, e_valid, e_instr, e_pc);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0b, want %0b", name, actual, expected);
    end
  endtask

  function automatic void add_vec(input string name, input logic gnt, input logic rvalid,
                                  input logic [31:0] rdata, input logic ready,
                                  input logic redirect, input logic [31:0] rpc,
                                  input logic e_req, input logic [31:0] e_addr,
                                  input logic e_valid, input logic [31:0] e_instr,
                                  input logic [31:0] e_pc, input logic chk_data);
    vec_t v;
    v.name = name;     v.gnt = gnt;       v.rvalid = rvalid; v.rdata = rdata;
    v.ready = ready;   v.redirect = redirect; v.rpc = rpc;
    v.e_req = e_req;   v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc = e_pc;   v.chk_data = chk_data;
    vec_q.push_back(v);
  endfunction

  initial begin
    // Each vector: outputs expected in this cycle, inputs driven in this cycle.
    //        name            gnt rv rdata          rdy rd rpc             req addr          vld instr          pc             chk
    add_vec("reset_idle",     0,  0, 32'h0,         0,  0, 32'h0,          0,  32'h0000_1000, 0,  32'h0,         32'h0000_1000, 1);
    add_vec("t1_req",         1,  0, 32'h0,         0,  0, 32'h0,          1,  32'h0000_1000, 0,  32'h0,         32'h0,         0);
    add_vec("t1_wait",        0,  1, 32'h0000_0093, 0,  0, 32'h0,          0,  32'h0000_1000, 0,  32'h0,         32'h0,         0);
    for (int i = 0; i < 5; i++) begin
      add_vec("t2_hold",      1,  1, 32'h1111_1111, 0,  0, 32'h0,          0,  32'h0000_1000, 1,  32'h0000_0093, 32'h0000_1000, 1);
    end
    add_vec("t1_accept",      0,  0, 32'h0,         1,  0, 32'h0,          0,  32'h0000_1000, 1,  32'h0000_0093, 32'h0000_1000, 1);
    add_vec("t1_req_1004",    1,  0, 32'h0,         0,  0, 32'h0,          1,  32'h0000_1004, 0,  32'h0,         32'h0,         0);
    add_vec("wait_1004",      0,  1, 32'h0000_0013, 0,  0, 32'h0,          0,  32'h0000_1004, 0,  32'h0,         32'h0,         0);
    add_vec("hold_1004",      0,  0, 32'h0,         1,  0, 32'h0,          0,  32'h0000_1004, 1,  32'h0000_0013, 32'h0000_1004, 1);
    add_vec("req_1008",       1,  0, 32'h0,         0,  0, 32'h0,          1,  32'h0000_1008, 0,  32'h0,         32'h0,         0);
    add_vec("wait_1008",      0,  1, 32'h0050_0113, 0,  0, 32'h0,          0,  32'h0000_1008, 0,  32'h0,         32'h0,         0);
    add_vec("t4_hold_redir",  0,  0, 32'h0,         1,  1, 32'h0000_3000,  0,  32'h0000_1008, 1,  32'h0050_0113, 32'h0000_1008, 1);
    add_vec("t4_req_3000",    0,  0, 32'h0,         0,  1, 32'hFFFF_FFFC,  1,  32'h0000_3000, 0,  32'h0,         32'h0,         0);
    add_vec("t5_req_top",     1,  0, 32'h0,         0,  0, 32'h0,          1,  32'hFFFF_FFFC, 0,  32'h0,         32'h0,         0);
    add_vec("t5_wait_a",      0,  0, 32'h0,         0,  0, 32'h0,          0,  32'hFFFF_FFFC, 0,  32'h0,         32'h0,         0);
    add_vec("t5_wait_b",      0,  1, 32'h0000_ABCD, 0,  0, 32'h0,          0,  32'hFFFF_FFFC, 0,  32'h0,         32'h0,         0);
    add_vec("t5_hold_top",    0,  0, 32'h0,         1,  0, 32'h0,          0,  32'hFFFF_FFFC, 1,  32'h0000_ABCD, 32'hFFFF_FFFC, 1);
    add_vec("t5_req_wrap",    1,  0, 32'h0,         0,  1, 32'h0000_4000,  1,  32'h0000_0000, 0,  32'h0,         32'h0,         0);
    add_vec("drain_4000",     0,  1, 32'h0000_0BAD, 0,  0, 32'h0,          0,  32'h0000_4000, 0,  32'h0,         32'h0,         0);
    add_vec("req_rv_ignored", 0,  1, 32'h0000_0111, 0,  0, 32'h0,          1,  32'h0000_4000, 0,  32'h0,         32'h0,         0);
    add_vec("req_4000_gnt",   1,  0, 32'h0,         0,  0, 32'h0,          1,  32'h0000_4000, 0,  32'h0,         32'h0,         0);
    add_vec("t3_wait_redir",  0,  0, 32'h0,         0,  1, 32'h0000_2000,  0,  32'h0000_4000, 0,  32'h0,         32'h0,         0);

    reset         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

`ifdef YARP_FETCH_MISALIGN_EN
    check_bit("reset_err", fetch_err_o, 1'b0);
`endif

    foreach (vec_q[i]) begin
      check_output(vec_q[i].name, vec_q[i].e_req, vec_q[i].e_addr, vec_q[i].e_valid,
                   vec_q[i].e_instr, vec_q[i].e_pc, vec_q[i].chk_data);
      apply_stimulus(vec_q[i].gnt, vec_q[i].rvalid, vec_q[i].rdata,
                     vec_q[i].ready, vec_q[i].redirect, vec_q[i].rpc);
    end

    // Stale response arrives three cycles after the redirect and is dropped.
    check_output("t3_drain_1", 0, 32'h0000_2000, 0, 32'h0, 32'h0, 0);
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0);
    check_output("t3_drain_2", 0, 32'h0000_2000, 0, 32'h0, 32'h0, 0);
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0);
    check_output("t3_drain_3", 0, 32'h0000_2000, 0, 32'h0, 32'h0, 0);
    apply_stimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
    check_output("t3_req_2000", 1, 32'h0000_2000, 0, 32'h0, 32'h0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);

    // Redirect coinciding with rvalid in WAIT drops the word and refetches.
    check_output("wait_2000", 0, 32'h0000_2000, 0, 32'h0, 32'h0, 0);
    apply_stimulus(0, 1, 32'h0000_CAFE, 0, 1, 32'h0000_2100);
    check_output("req_2100", 1, 32'h0000_2100, 0, 32'h0, 32'h0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);
    check_output("wait_2100", 0, 32'h0000_2100, 0, 32'h0, 32'h0, 0);
    apply_stimulus(0, 1, 32'h0000_0055, 0, 0, 32'h0);
    check_output("hold_2100", 0, 32'h0000_2100, 1, 32'h0000_0055, 32'h0000_2100, 1);

    // Misaligned redirect target from HOLD.
    apply_stimulus(0, 0, 32'h0, 0, 1, 32'h0000_2002);
`ifdef YARP_FETCH_MISALIGN_EN
    for (int i = 0; i < 4; i++) begin
      check_bit("t6_err_sticky", fetch_err_o, 1'b1);
      check_output("t6_halted", 0, 32'h0000_2000, 0, 32'h0, 32'h0, 0);
      apply_stimulus(1, 1, 32'h0000_0BAD, 1, 0, 32'h0);
    end
`else
    check_output("t6_req_2000", 1, 32'h0000_2000, 0, 32'h0, 32'h0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);
    check_output("t6_wait_2000", 0, 32'h0000_2000, 0, 32'h0, 32'h0, 0);
`endif

    // Reset mid-transaction; rvalid in the first cycle after reset is ignored.
    reset = 1'b1;
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0);
    reset = 1'b0;
    check_output("rst2_idle", 0, 32'h0000_1000, 0, 32'h0, 32'h0000_1000, 1);
`ifdef YARP_FETCH_MISALIGN_EN
    check_bit("rst2_err", fetch_err_o, 1'b0);
`endif
    apply_stimulus(0, 1, 32'h0000_0077, 0, 0, 32'h0);
    check_output("rst2_req", 1, 32'h0000_1000, 0, 32'h0, 32'h0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);
    check_output("rst2_wait", 0, 32'h0000_1000, 0, 32'h0, 32'h0, 0);
    apply_stimulus(0, 1, 32'h0000_0099, 0, 0, 32'h0);
    check_output("rst2_hold", 0, 32'h0000_1000, 1, 32'h0000_0099, 32'h0000_1000, 1);
    apply_stimulus(0, 0, 32'h0, 1, 0, 32'h0);
    check_output("rst2_req_1004", 1, 32'h0000_1004, 0, 32'h0, 32'h0, 0);

    check_bit("dropped_never_valid", saw_dropped, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
